// File: rtl/cond_branch_unit.sv
// Conditional branch resolver: pairs a branch request with one captured comparator
// flag set, evaluates the condition code and hands the decision to a consumer.
module cond_branch_unit #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flag_valid,
  output logic          flag_ready,
  input  logic          flag_r,
  input  logic          flag_z,
  input  logic          flag_n,
  input  logic          br_valid,
  output logic          br_ready,
  input  logic [2:0]    br_cond,
  input  logic [31:0]   br_target,
  output logic          take_valid,
  input  logic          take_ready,
  output logic          take,
  output logic [31:0]   take_target,
  output logic [CW-1:0] resolved_cnt,
  output logic [CW-1:0] taken_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, EVAL, RESP} state_t;

  state_t      state, state_next;
  logic        stat_r, stat_z, stat_n, stat_valid;
  logic [2:0]  cond;
  logic [31:0] target;
  logic        capture, accept, handshake, cond_met;

  assign flag_ready = (state == IDLE) || (state == WAIT);
  assign br_ready   = (state == IDLE);
  assign capture    = flag_valid && flag_ready;
  assign accept     = br_valid && br_ready;
  assign handshake  = (state == RESP) && take_valid && take_ready;

  // Flags captured on the accepting edge are already registered by EVAL.
  always_comb begin
    cond_met = 1'b0;
    case (cond)
      3'b000:  cond_met = 1'b1;
      3'b001:  cond_met = stat_r;
      3'b010:  cond_met = !stat_r;
      3'b011:  cond_met = stat_z;
      3'b100:  cond_met = !stat_z;
      3'b101:  cond_met = stat_n;
      3'b110:  cond_met = !stat_n;
      default: cond_met = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = (stat_valid || capture) ? EVAL : WAIT;
      WAIT: if (capture) state_next = EVAL;
      EVAL: state_next = RESP;
      RESP: if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A capture in IDLE simply overwrites flags not yet consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_r     <= 1'b0;
      stat_z     <= 1'b0;
      stat_n     <= 1'b0;
      stat_valid <= 1'b0;
    end else if (capture) begin
      stat_r     <= flag_r;
      stat_z     <= flag_z;
      stat_n     <= flag_n;
      stat_valid <= 1'b1;
    end else if (state == EVAL) begin
      stat_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond   <= 3'b000;
      target <= 32'h0;
    end else if (accept) begin
      cond   <= br_cond;
      target <= br_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      take_valid   <= 1'b0;
      take         <= 1'b0;
      take_target  <= 32'h0;
      resolved_cnt <= '0;
      taken_cnt    <= '0;
    end else if (state == EVAL) begin
      take_valid  <= 1'b1;
      take        <= cond_met;
      take_target <= target;
    end else if (handshake) begin
      take_valid   <= 1'b0;
      resolved_cnt <= resolved_cnt + 1'b1;
      taken_cnt    <= taken_cnt + {{(CW-1){1'b0}}, take};
    end
  end

endmodule

// File: tb/tb_cond_branch_unit.sv
// Directed bench for cond_branch_unit (CW=4 so counter wrap is reachable quickly).
module tb_cond_branch_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flag_valid, flag_r, flag_z, flag_n;
  logic          flag_ready;
  logic          br_valid;
  logic          br_ready;
  logic [2:0]    br_cond;
  logic [31:0]   br_target;
  logic          take_valid, take_ready, take;
  logic [31:0]   take_target;
  logic [CW-1:0] resolved_cnt, taken_cnt;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_res = '0;
  logic [CW-1:0] exp_taken = '0;

  cond_branch_unit #(.CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .flag_valid(flag_valid), .flag_ready(flag_ready),
    .flag_r(flag_r), .flag_z(flag_z), .flag_n(flag_n),
    .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_target(br_target),
    .take_valid(take_valid), .take_ready(take_ready),
    .take(take), .take_target(take_target),
    .resolved_cnt(resolved_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_take(input logic [2:0] c, input logic [2:0] rzn);
    case (c)
      3'd0: return 1'b1;
      3'd1: return rzn[2];
      3'd2: return !rzn[2];
      3'd3: return rzn[1];
      3'd4: return !rzn[1];
      3'd5: return rzn[0];
      3'd6: return !rzn[0];
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_counters(input string tag);
    check({tag, " resolved_cnt"}, 32'(resolved_cnt), 32'(exp_res));
    check({tag, " taken_cnt"}, 32'(taken_cnt), 32'(exp_taken));
  endtask

  task automatic handshake(input logic exp_t, input string tag);
    take_ready = 1'b1;
    tick();
    take_ready = 1'b0;
    exp_res   = exp_res + 1'b1;
    exp_taken = exp_taken + CW'(exp_t);
    check({tag, " take_valid after handshake"}, 32'(take_valid), 32'd0);
    check_counters(tag);
  endtask

  // Flags and branch offered on the same edge, then decision consumed.
  task automatic run_branch(input logic [2:0] c, input logic [2:0] rzn,
                            input logic [31:0] tgt, input string tag);
    logic exp_t;
    exp_t = ref_take(c, rzn);
    flag_valid = 1'b1;
    {flag_r, flag_z, flag_n} = rzn;
    br_valid = 1'b1;
    br_cond = c;
    br_target = tgt;
    tick();
    flag_valid = 1'b0;
    br_valid = 1'b0;
    check({tag, " take_valid in EVAL"}, 32'(take_valid), 32'd0);
    tick();
    check({tag, " take_valid"}, 32'(take_valid), 32'd1);
    check({tag, " take"}, 32'(take), 32'(exp_t));
    check({tag, " take_target"}, take_target, tgt);
    handshake(exp_t, tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " take_valid"}, 32'(take_valid), 32'd0);
    check({tag, " take"}, 32'(take), 32'd0);
    check({tag, " take_target"}, take_target, 32'd0);
    check({tag, " resolved_cnt"}, 32'(resolved_cnt), 32'd0);
    check({tag, " taken_cnt"}, 32'(taken_cnt), 32'd0);
    check({tag, " br_ready"}, 32'(br_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    flag_valid = 1'b0; flag_r = 1'b0; flag_z = 1'b0; flag_n = 1'b0;
    br_valid = 1'b0; br_cond = 3'd0; br_target = 32'h0; take_ready = 1'b0;
    #3;
    check_zero("reset");
    check("reset flag_ready", 32'(flag_ready), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Flags first, branch next cycle.
    flag_valid = 1'b1; {flag_r, flag_z, flag_n} = 3'b100;
    tick();
    flag_valid = 1'b0;
    br_valid = 1'b1; br_cond = 3'b001; br_target = 32'h100;
    tick();
    br_valid = 1'b0;
    check("basic br_ready in EVAL", 32'(br_ready), 32'd0);
    check("basic flag_ready in EVAL", 32'(flag_ready), 32'd0);
    check("basic take_valid in EVAL", 32'(take_valid), 32'd0);
    tick();
    check("basic take_valid", 32'(take_valid), 32'd1);
    check("basic take", 32'(take), 32'd1);
    check("basic take_target", take_target, 32'h100);
    check("basic br_ready in RESP", 32'(br_ready), 32'd0);
    handshake(1'b1, "basic");
    check("basic br_ready after", 32'(br_ready), 32'd1);

    // Branch waits for flags.
    br_valid = 1'b1; br_cond = 3'b011; br_target = 32'h2000;
    tick();
    br_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("wait take_valid", 32'(take_valid), 32'd0);
      check("wait flag_ready", 32'(flag_ready), 32'd1);
      check("wait br_ready", 32'(br_ready), 32'd0);
    end
    flag_valid = 1'b1; {flag_r, flag_z, flag_n} = 3'b010;
    tick();
    flag_valid = 1'b0;
    tick();
    check("wait take_valid", 32'(take_valid), 32'd1);
    check("wait take", 32'(take), 32'd1);
    check("wait take_target", take_target, 32'h2000);
    handshake(1'b1, "wait");

    run_branch(3'b001, 3'b000, 32'h300, "same_edge");

    // Back-pressure in RESP; flag pulse during RESP is dropped.
    flag_valid = 1'b1; {flag_r, flag_z, flag_n} = 3'b100;
    br_valid = 1'b1; br_cond = 3'b001; br_target = 32'hABC;
    tick();
    flag_valid = 1'b0; br_valid = 1'b0;
    tick();
    flag_valid = 1'b1; {flag_r, flag_z, flag_n} = 3'b011;
    for (int i = 0; i < 5; i++) begin
      tick();
      flag_valid = 1'b0;
      check("stall take_valid", 32'(take_valid), 32'd1);
      check("stall take", 32'(take), 32'd1);
      check("stall take_target", take_target, 32'hABC);
      check("stall flag_ready", 32'(flag_ready), 32'd0);
      check("stall br_ready", 32'(br_ready), 32'd0);
    end
    handshake(1'b1, "stall");
    br_valid = 1'b1; br_cond = 3'b000; br_target = 32'h44;
    tick();
    br_valid = 1'b0;
    tick();
    check("dropped flags take_valid", 32'(take_valid), 32'd0);
    check("dropped flags in WAIT", 32'(flag_ready), 32'd1);

    // Reset while in WAIT.
    rst_n = 1'b0;
    #1;
    check_zero("rst_wait");
    rst_n = 1'b1;
    exp_res = '0; exp_taken = '0;
    tick();

    // Reset while in RESP.
    flag_valid = 1'b1; {flag_r, flag_z, flag_n} = 3'b000;
    br_valid = 1'b1; br_cond = 3'b000; br_target = 32'h55;
    tick();
    flag_valid = 1'b0; br_valid = 1'b0;
    tick();
    check("pre_rst take_valid", 32'(take_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero("rst_resp");
    rst_n = 1'b1;
    tick();
    br_valid = 1'b1; br_cond = 3'b000; br_target = 32'h66;
    tick();
    br_valid = 1'b0;
    tick();
    check("post_rst take_valid", 32'(take_valid), 32'd0);
    check("post_rst flag_ready", 32'(flag_ready), 32'd1);
    flag_valid = 1'b1; {flag_r, flag_z, flag_n} = 3'b000;
    tick();
    flag_valid = 1'b0;
    tick();
    check("post_rst take", 32'(take), 32'd1);
    handshake(1'b1, "post_rst");

    // Full condition map across several flag patterns.
    for (int p = 0; p < 3; p++) begin
      logic [2:0] rzn;
      rzn = (p == 0) ? 3'b100 : (p == 1) ? 3'b011 : 3'b010;
      for (int c = 0; c < 8; c++)
        run_branch(3'(c), rzn, 32'h1000 + 32'(c) + 32'(p * 16), "cond_map");
    end

    // Counter wrap: 16 taken decisions from reset land back on zero.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    exp_res = '0; exp_taken = '0;
    tick();
    for (int i = 0; i < 16; i++) run_branch(3'b000, 3'b000, 32'(i), "wrap");
    check("wrap resolved zero", 32'(resolved_cnt), 32'd0);
    check("wrap taken zero", 32'(taken_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
